nfu_3_act_pipe: RTL and testbench
=================================

// Module: nfu_3_act_pipe
// PURPOSE
//  NFU-3 stage, directly downstream of the NFU-2 adder trees. Applies a
//  piecewise-linear activation y = sat((a[s]*x >>> FRAC_BITS) + b[s]) to Tn
//  fixed-point neuron sums in parallel. The Tn lanes share one runtime-loadable
//  segment coefficient table. 2-stage valid/ready pipeline that supports backpressure.
// PARAMETERS
//  BIT_WIDTH  16  data/coefficient width, signed two's complement
//  FRAC_BITS  8   fractional bits (Q7.8); product shift amount
//  Tn         16  number of parallel lanes (NFU-2 tree count)
//  SEG_BITS   4   log2(number of segments); table depth = 2**SEG_BITS
// PORTS
//  clk        in   1               single clock, rising edge
//  rst        in   1               synchronous reset, active-high
//  i_valid    in   1               i_data holds Tn valid NFU-2 sums
//  o_ready    out  1               stage can accept i_data this cycle
//  i_data     in   BIT_WIDTH*Tn    lane k = bits [(k+1)*BIT_WIDTH-1 : k*BIT_WIDTH]
//  i_ready    in   1               downstream (NBout/NBin writeback) accepts o_data
//  o_valid    out  1               o_data valid
//  o_data     out  BIT_WIDTH*Tn    activated outputs, same lane packing
//  o_sat      out  Tn              per-lane saturation flag, qualified by o_valid
//  cfg_we     in   1               coefficient table write strobe
//  cfg_addr   in   SEG_BITS        segment index to write
//  cfg_a      in   BIT_WIDTH       slope, Q7.8 signed
//  cfg_b      in   BIT_WIDTH       intercept, Q7.8 signed
// BEHAVIOUR
//  - Reset (sync): S1/S2 valid=0; o_valid=0, o_data=0, o_sat=0; o_ready=1 on the
//    first cycle after reset; all table entries set to a=1.0 (1<<FRAC_BITS), b=0
//    (identity).
//  - Segment index s = {~x[MSB], x[MSB-1 -: SEG_BITS-1]}, i.e. offset-binary top
//    bits. Segments are uniform and span the full signed range.
//  - S1 (on accept): registers x, a[s], b[s] per lane. Coefficients are captured
//    here, so a table write never alters data already in flight.
//  - S2: p = a*x (2*BIT_WIDTH signed); t = (p >>> FRAC_BITS) + sext(b). Saturate t
//    to [-2^(BW-1), 2^(BW-1)-1] and set o_sat[k] when clipped. The S2 register
//    drives o_data/o_valid/o_sat.
//  - Latency: 2 cycles from accept (i_valid&o_ready) to o_valid with no stall.
//    Throughput: 1 vector/cycle.
//  - Handshake: a stage advances when its downstream slot is empty or is draining
//    this cycle. o_ready = !S1.valid | !S2.valid | i_ready (bubbles collapse).
//    While o_valid&!i_ready, o_data/o_sat hold stable. Upstream must hold i_data
//    while i_valid&!o_ready.
//  - Output transfer occurs on o_valid&i_ready. Simultaneous accept and drain
//    in the same cycle is lossless.
//  - cfg_we writes the entry on the clock edge. If cfg_we coincides with an accept
//    that indexes the same entry, S1 captures the OLD value; the new value applies
//    from the next accept onward. Writes are allowed at any time, including
//    during stalls.
//  - rst asserted mid-operation: all in-flight vectors are discarded (no o_valid
//    after reset) and the table returns to identity.
// CONFIGURATION
//  NFU3_BYPASS_EN defined: adds input i_bypass (1 bit), sampled with i_data on
//    accept and carried through the pipeline. When set, the vector passes through
//    unchanged (o_data = x, o_sat = 0) with the same 2-cycle latency. This is used
//    for layers with no activation and for partial-sum writeback.
//  NFU3_BYPASS_EN undefined: i_bypass does not exist; every vector is activated.
// TESTING
//  1 Reset, no cfg writes; lane0 x=0x0340, valid 1 cycle -> 2 cycles later
//    o_valid=1, lane0 y=0x0340, o_sat=0 (identity).
//  2 Write s=8 a=0x0080 b=0x0100; x=0x0340 -> y=0x02A0. Also x=0xF000 (s=7,
//    still identity) -> y=0xF000.
//  3 Write s=8 a=0x7FFF b=0; x=0x0FFF -> y=0x7FFF, o_sat[0]=1.
//    Write s=0 a=0x7FFF; x=0x8000 -> y=0x8000, o_sat[0]=1.
//  4 Stream 6 back-to-back vectors with i_ready low for cycles 3-5 -> o_data held
//    stable while stalled, o_ready=0 once S1 and S2 are full, all 6 outputs
//    delivered in order with no loss or duplication.
//  5 cfg_we to s=8 in the same cycle as accepting x=0x0340 -> that vector uses the
//    old coefficients; the next x=0x0340 uses the new ones.
//  6 rst pulsed with both stages valid -> o_valid=0 the following cycle, no stale
//    output afterwards; x=0x0340 -> y=0x0340 (table back to identity).
//    With NFU3_BYPASS_EN defined: i_bypass=1, s=8 a=0x7FFF, x=0x0FFF -> y=0x0FFF,
//    o_sat=0.

Source files
------------

// File: rtl/nfu_3_act_pipe.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | nfu_3_act_pipe : NFU-3 piecewise-linear activation, Tn lanes, 2-stage     |
// |   valid/ready pipeline with shared runtime-loadable segment table.        |
// |   Optional macro NFU3_BYPASS_EN adds i_bypass (pass-through vectors).     |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module nfu_3_act_pipe #(
  parameter int BIT_WIDTH = 16,
  parameter int FRAC_BITS = 8,
  parameter int Tn        = 16,
  parameter int SEG_BITS  = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_valid,
  output logic                      o_ready,
  input  logic [BIT_WIDTH*Tn-1:0]   i_data,
`ifdef NFU3_BYPASS_EN
  input  logic                      i_bypass,
`endif
  input  logic                      i_ready,
  output logic                      o_valid,
  output logic [BIT_WIDTH*Tn-1:0]   o_data,
  output logic [Tn-1:0]             o_sat,
  input  logic                      cfg_we,
  input  logic [SEG_BITS-1:0]       cfg_addr,
  input  logic [BIT_WIDTH-1:0]      cfg_a,
  input  logic [BIT_WIDTH-1:0]      cfg_b
);

  localparam int DEPTH = 1 << SEG_BITS;
  localparam int PW    = 2 * BIT_WIDTH;
  localparam logic [BIT_WIDTH-1:0] A_ONE = BIT_WIDTH'(1) << FRAC_BITS;
  localparam logic [BIT_WIDTH-1:0] Y_MAX = {1'b0, {(BIT_WIDTH-1){1'b1}}};
  localparam logic [BIT_WIDTH-1:0] Y_MIN = {1'b1, {(BIT_WIDTH-1){1'b0}}};

  logic [BIT_WIDTH-1:0] tab_a_q [DEPTH];
  logic [BIT_WIDTH-1:0] tab_b_q [DEPTH];

  logic                          s1_valid_q, s2_valid_q;
  logic                          s1_byp_q;
  logic [Tn-1:0][BIT_WIDTH-1:0]  s1_x_q, s1_a_q, s1_b_q;
  logic [Tn-1:0][BIT_WIDTH-1:0]  s2_y_q;
  logic [Tn-1:0]                 s2_sat_q;

  logic [Tn-1:0][BIT_WIDTH-1:0]  sel_a, sel_b, y_d;
  logic [Tn-1:0]                 sat_d;
  logic                          byp_in;
  logic                          s1_adv, s2_adv, accept;

`ifdef NFU3_BYPASS_EN
  assign byp_in = i_bypass;
`else
  assign byp_in = 1'b0;
`endif

  // A stage advances when the slot ahead is empty or draining this cycle.
  assign s2_adv  = !s2_valid_q | i_ready;
  assign s1_adv  = !s1_valid_q | s2_adv;
  assign accept  = i_valid & s1_adv;
  assign o_ready = s1_adv;

  assign o_valid = s2_valid_q;
  assign o_data  = s2_y_q;
  assign o_sat   = s2_sat_q;

  for (genvar k = 0; k < Tn; k++) begin : g_lane
    logic [BIT_WIDTH-1:0] x_in;
    logic [SEG_BITS-1:0]  seg;
    logic [PW-1:0]        prod;
    logic signed [PW-1:0] shifted;
    logic signed [PW-1:0] sum;
    logic                 clip;

    assign x_in = i_data[k*BIT_WIDTH +: BIT_WIDTH];
    // Offset-binary top bits: uniform segments across the signed range.
    assign seg      = {~x_in[BIT_WIDTH-1], x_in[BIT_WIDTH-2 -: SEG_BITS-1]};
    assign sel_a[k] = tab_a_q[seg];
    assign sel_b[k] = tab_b_q[seg];

    assign prod    = {{BIT_WIDTH{s1_a_q[k][BIT_WIDTH-1]}}, s1_a_q[k]} *
                     {{BIT_WIDTH{s1_x_q[k][BIT_WIDTH-1]}}, s1_x_q[k]};
    assign shifted = $signed(prod) >>> FRAC_BITS;
    assign sum     = shifted + $signed({{BIT_WIDTH{s1_b_q[k][BIT_WIDTH-1]}}, s1_b_q[k]});
    assign clip    = !((&sum[PW-1:BIT_WIDTH-1]) | !(|sum[PW-1:BIT_WIDTH-1]));

    always_comb begin
      y_d[k]   = sum[BIT_WIDTH-1:0];
      sat_d[k] = clip;
      if (s1_byp_q) begin
        y_d[k]   = s1_x_q[k];
        sat_d[k] = 1'b0;
      end else if (clip) begin
        y_d[k] = sum[PW-1] ? Y_MIN : Y_MAX;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      s1_byp_q   <= 1'b0;
      s1_x_q     <= '0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s2_y_q     <= '0;
      s2_sat_q   <= '0;
      for (int e = 0; e < DEPTH; e++) begin
        tab_a_q[e] <= A_ONE;
        tab_b_q[e] <= '0;
      end
    end else begin
      // S1 reads the pre-write table, so a same-edge write only affects later accepts.
      if (cfg_we) begin
        tab_a_q[cfg_addr] <= cfg_a;
        tab_b_q[cfg_addr] <= cfg_b;
      end
      if (s1_adv) s1_valid_q <= i_valid;
      if (accept) begin
        s1_x_q   <= i_data;
        s1_a_q   <= sel_a;
        s1_b_q   <= sel_b;
        s1_byp_q <= byp_in;
      end
      if (s2_adv) begin
        s2_valid_q <= s1_valid_q;
        if (s1_valid_q) begin
          s2_y_q   <= y_d;
          s2_sat_q <= sat_d;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_nfu_3_act_pipe.sv
`default_nettype none
// Testbench for nfu_3_act_pipe: randomized and directed vectors against a
// queue-based arithmetic reference of the activation pipeline.
module tb_nfu_3_act_pipe;
  localparam int BW = 16;
  localparam int TN = 16;
  localparam int SB = 4;
  localparam int DW = BW * TN;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_valid, o_ready, i_ready, o_valid;
  logic [DW-1:0] i_data, o_data;
  logic [TN-1:0] o_sat;
  logic          cfg_we;
  logic [SB-1:0] cfg_addr;
  logic [BW-1:0] cfg_a, cfg_b;
`ifdef NFU3_BYPASS_EN
  logic          bypass;
`endif

  always #5 clk = ~clk;

  nfu_3_act_pipe dut (
    .clk(clk), .rst(rst),
    .i_valid(i_valid), .o_ready(o_ready), .i_data(i_data),
`ifdef NFU3_BYPASS_EN
    .i_bypass(bypass),
`endif
    .i_ready(i_ready), .o_valid(o_valid), .o_data(o_data), .o_sat(o_sat),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_a(cfg_a), .cfg_b(cfg_b)
  );

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;

  int tab_a [16];
  int tab_b [16];
  typedef struct { logic [DW-1:0] d; logic [TN-1:0] s; int avail; } item_t;
  item_t q[$];

  logic          obs_valid, obs_ready, exp_valid, exp_ready, exp_drain;
  logic [DW-1:0] obs_data, exp_data;
  logic [TN-1:0] obs_sat, exp_sat;

  function automatic void model_reset();
    for (int e = 0; e < 16; e++) begin
      tab_a[e] = 256;
      tab_b[e] = 0;
    end
    q.delete();
  endfunction

  // y = sat(floor(a*x / 2^8) + b), segment = (x + 2^15) / 2^12
  function automatic void act(input logic [DW-1:0] x, input logic byp,
                              output logic [DW-1:0] y, output logic [TN-1:0] s);
    int xi, seg;
    longint t;
    for (int k = 0; k < TN; k++) begin
      xi  = int'($signed(x[k*BW +: BW]));
      seg = (xi + 32768) / 4096;
      t   = ((longint'(tab_a[seg]) * longint'(xi)) >>> 8) + longint'(tab_b[seg]);
      s[k] = 1'b0;
      if (t > 32767) begin t = 32767; s[k] = 1'b1; end
      if (t < -32768) begin t = -32768; s[k] = 1'b1; end
      y[k*BW +: BW] = 16'(t);
      if (byp) begin
        y[k*BW +: BW] = x[k*BW +: BW];
        s[k] = 1'b0;
      end
    end
  endfunction

  function automatic logic [DW-1:0] rvec(input logic [15:0] l0);
    logic [DW-1:0] v;
    for (int k = 0; k < TN; k++) v[k*BW +: BW] = 16'($urandom);
    v[15:0] = l0;
    return v;
  endfunction

  task automatic drive_idle();
    i_valid = 1'b0; i_data = '0; i_ready = 1'b1;
    cfg_we = 1'b0; cfg_addr = '0; cfg_a = '0; cfg_b = '0;
`ifdef NFU3_BYPASS_EN
    bypass = 1'b0;
`endif
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    drive_idle();
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  // One cycle: drive at negedge, sample 1 ns later, advance the reference model.
  task automatic step(input logic v, input logic [DW-1:0] d, input logic byp,
                      input logic rdy, input logic we, input logic [3:0] wa,
                      input logic [15:0] ca, input logic [15:0] cb);
    logic [DW-1:0] y;
    logic [TN-1:0] s;
    item_t it;
    @(negedge clk);
    i_valid = v; i_data = d; i_ready = rdy;
    cfg_we = we; cfg_addr = wa; cfg_a = ca; cfg_b = cb;
`ifdef NFU3_BYPASS_EN
    bypass = byp;
`endif
    #1;
    obs_valid = o_valid; obs_ready = o_ready; obs_data = o_data; obs_sat = o_sat;
    exp_ready = (q.size() < 2) || rdy;
    exp_valid = (q.size() > 0) && (q[0].avail <= cyc);
    exp_drain = exp_valid && rdy;
    exp_data  = '0;
    exp_sat   = '0;
    if (exp_drain) begin
      exp_data = q[0].d;
      exp_sat  = q[0].s;
      void'(q.pop_front());
      if (q.size() > 0) begin
        it = q.pop_front();
        if (it.avail < cyc + 1) it.avail = cyc + 1;
        q.push_front(it);
      end
    end
    if (v && exp_ready) begin
      act(d, byp, y, s);
      it.d = y; it.s = s; it.avail = cyc + 2;
      q.push_back(it);
    end
    if (we) begin
      tab_a[wa] = int'($signed(ca));
      tab_b[wa] = int'($signed(cb));
    end
    cyc++;
  endtask

  task automatic test_reset();
    do_reset();
    step(1'b0, '0, 1'b0, 1'b1, 1'b0, 4'd0, 16'd0, 16'd0);
    n_checks++; if (obs_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got=%b want=0", obs_valid); end
    n_checks++; if (obs_data !== '0) begin n_err++; $display("FAIL reset_data got=%h want=0", obs_data); end
    n_checks++; if (obs_sat !== '0) begin n_err++; $display("FAIL reset_sat got=%h want=0", obs_sat); end
    n_checks++; if (obs_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready got=%b want=1", obs_ready); end
  endtask

  task automatic test_identity();
    do_reset();
    step(1'b1, rvec(16'h0340), 1'b0, 1'b1, 1'b0, 4'd0, 16'd0, 16'd0);
    step(1'b0, '0, 1'b0, 1'b1, 1'b0, 4'd0, 16'd0, 16'd0);
    n_checks++; if (obs_valid !== 1'b0) begin n_err++; $display("FAIL ident_early got=%b want=0", obs_valid); end
    step(1'b0, '0, 1'b0, 1'b1, 1'b0, 4'd0, 16'd0, 16'd0);
    n_checks++; if (obs_valid !== 1'b1) begin n_err++; $display("FAIL ident_latency got=%b want=1", obs_valid); end
    n_checks++; if (obs_data[15:0] !== 16'h0340) begin n_err++; $display("FAIL ident_lane0 got=%h want=0340", obs_data[15:0]); end
    n_checks++; if (obs_data !== exp_data || obs_sat !== exp_sat) begin n_err++; $display("FAIL ident_vec got=%h/%h want=%h/%h", obs_data, obs_sat, exp_data, exp_sat); end
  endtask

  // Runs directed accepts (lane0 given) then drains, checking lane0 against want0/wsat0.
  task automatic test_coeff();
    logic [15:0] got0 [$];
    logic        gsat [$];
    do_reset();
    step(1'b0, '0, 1'b0, 1'b1, 1'b1, 4'd8, 16'h0080, 16'h0100);
    step(1'b1, rvec(16'h0340), 1'b0, 1'b1, 1'b0, 4'd0, 16'd0, 16'd0);
    step(1'b1, rvec(16'hF000), 1'b0, 1'b1, 1'b0, 4'd0, 16'd0, 16'd0);
    for (int c = 0; c < 6; c++) begin
      step(1'b0, '0, 1'b0, 1'b1, 1'b0, 4'd0, 16'd0, 16'd0);
      if (obs_valid) begin got0.push_back(obs_data[15:0]); gsat.push_back(obs_sat[0]); end
      n_checks++; if (obs_valid !== exp_valid || (exp_drain && (obs_data !== exp_data || obs_sat !== exp_sat))) begin
        n_err++; $display("FAIL coeff_vec got=%b %h want=%b %h", obs_valid, obs_data, exp_valid, exp_data); end
    end
    n_checks++; if (got0.size() != 2) begin n_err++; $display("FAIL coeff_count got=%0d want=2", got0.size()); end
    else begin
      n_checks++; if (got0[0] !== 16'h02A0) begin n_err++; $display("FAIL coeff_s8 got=%h want=02A0", got0[0]); end
      n_checks++; if (got0[1] !== 16'hF000) begin n_err++; $display("FAIL coeff_s7 got=%h want=F000", got0[1]); end
    end
  endtask

  task automatic test_sat();
    logic [15:0] got0 [$];
    logic        gsat [$];
    do_reset();
    step(1'b0, '0, 1'b0, 1'b1, 1'b1, 4'd8, 16'h7FFF, 16'h0000);
    step(1'b0, '0, 1'b0, 1'b1, 1'b1, 4'd0, 16'h7FFF, 16'h0000);
    step(1'b1, rvec(16'h0FFF), 1'b0, 1'b1, 1'b0, 4'd0, 16'd0, 16'd0);
    step(1'b1, rvec(16'h8000), 1'b0, 1'b1, 1'b0, 4'd0, 16'd0, 16'd0);
    for (int c = 0; c < 6; c++) begin
      step(1'b0, '0, 1'b0, 1'b1, 1'b0, 4'd0, 16'd0, 16'd0);
      if (obs_valid) begin got0.push_back(obs_data[15:0]); gsat.push_back(obs_sat[0]); end
      n_checks++; if (obs_valid !== exp_valid || (exp_drain && (obs_data !== exp_data || obs_sat !== exp_sat))) begin
        n_err++; $display("FAIL sat_vec got=%b %h/%h want=%b %h/%h", obs_valid, obs_data, obs_sat, exp_valid, exp_data, exp_sat); end
    end
    n_checks++; if (got0.size() != 2) begin n_err++; $display("FAIL sat_count got=%0d want=2", got0.size()); end
    else begin
      n_checks++; if (got0[0] !== 16'h7FFF || gsat[0] !== 1'b1) begin n_err++; $display("FAIL sat_pos got=%h/%b want=7FFF/1", got0[0], gsat[0]); end
      n_checks++; if (got0[1] !== 16'h8000 || gsat[1] !== 1'b1) begin n_err++; $display("FAIL sat_neg got=%h/%b want=8000/1", got0[1], gsat[1]); end
    end
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] vecs [6];
    logic [DW-1:0] prev_data;
    logic          prev_stall, saw_nr, rdy;
    int            idx, ndrain;
    do_reset();
    for (int i = 0; i < 6; i++) vecs[i] = rvec(16'($urandom));
    idx = 0; ndrain = 0; prev_stall = 1'b0; saw_nr = 1'b0; prev_data = '0;
    for (int c = 1; c <= 20; c++) begin
      rdy = !(c >= 3 && c <= 5);
      step(idx < 6, (idx < 6) ? vecs[idx] : '0, 1'b0, rdy, 1'b0, 4'd0, 16'd0, 16'd0);
      if (idx < 6 && exp_ready) idx++;
      if (!obs_ready) saw_nr = 1'b1;
      n_checks++; if (obs_ready !== exp_ready || obs_valid !== exp_valid) begin
        n_err++; $display("FAIL b2b_hs c=%0d got=%b%b want=%b%b", c, obs_ready, obs_valid, exp_ready, exp_valid); end
      if (prev_stall) begin
        n_checks++; if (obs_data !== prev_data) begin n_err++; $display("FAIL b2b_hold c=%0d got=%h want=%h", c, obs_data, prev_data); end
      end
      if (exp_drain) begin
        n_checks++; if (obs_data !== exp_data || obs_sat !== exp_sat) begin
          n_err++; $display("FAIL b2b_data c=%0d got=%h want=%h", c, obs_data, exp_data); end
      end
      if (obs_valid && rdy) ndrain++;
      prev_stall = obs_valid && !rdy;
      prev_data  = obs_data;
    end
    n_checks++; if (saw_nr !== 1'b1) begin n_err++; $display("FAIL b2b_ready_low got=%b want=1", saw_nr); end
    n_checks++; if (ndrain != 6) begin n_err++; $display("FAIL b2b_count got=%0d want=6", ndrain); end
  endtask

  task automatic test_cfg_collision();
    logic [15:0] got0 [$];
    do_reset();
    step(1'b1, rvec(16'h0340), 1'b0, 1'b1, 1'b1, 4'd8, 16'h0080, 16'h0100);
    step(1'b1, rvec(16'h0340), 1'b0, 1'b1, 1'b0, 4'd0, 16'd0, 16'd0);
    for (int c = 0; c < 6; c++) begin
      step(1'b0, '0, 1'b0, 1'b1, 1'b0, 4'd0, 16'd0, 16'd0);
      if (obs_valid) got0.push_back(obs_data[15:0]);
      n_checks++; if (obs_valid !== exp_valid || (exp_drain && obs_data !== exp_data)) begin
        n_err++; $display("FAIL coll_vec got=%b %h want=%b %h", obs_valid, obs_data, exp_valid, exp_data); end
    end
    n_checks++; if (got0.size() != 2) begin n_err++; $display("FAIL coll_count got=%0d want=2", got0.size()); end
    else begin
      n_checks++; if (got0[0] !== 16'h0340) begin n_err++; $display("FAIL coll_old got=%h want=0340", got0[0]); end
      n_checks++; if (got0[1] !== 16'h02A0) begin n_err++; $display("FAIL coll_new got=%h want=02A0", got0[1]); end
    end
  endtask

  task automatic test_reset_midflight();
    do_reset();
    step(1'b0, '0, 1'b0, 1'b0, 1'b1, 4'd8, 16'h7FFF, 16'h0100);
    step(1'b1, rvec(16'h1234), 1'b0, 1'b0, 1'b0, 4'd0, 16'd0, 16'd0);
    step(1'b1, rvec(16'h2345), 1'b0, 1'b0, 1'b0, 4'd0, 16'd0, 16'd0);
    step(1'b0, '0, 1'b0, 1'b0, 1'b0, 4'd0, 16'd0, 16'd0);
    n_checks++; if (obs_valid !== 1'b1 || obs_ready !== 1'b0) begin
      n_err++; $display("FAIL mid_full got=%b%b want=10", obs_valid, obs_ready); end
    do_reset();
    for (int c = 0; c < 4; c++) begin
      step(1'b0, '0, 1'b0, 1'b1, 1'b0, 4'd0, 16'd0, 16'd0);
      n_checks++; if (obs_valid !== 1'b0 || obs_data !== '0) begin
        n_err++; $display("FAIL mid_stale c=%0d got=%b %h want=0 0", c, obs_valid, obs_data); end
    end
    step(1'b1, rvec(16'h0340), 1'b0, 1'b1, 1'b0, 4'd0, 16'd0, 16'd0);
    step(1'b0, '0, 1'b0, 1'b1, 1'b0, 4'd0, 16'd0, 16'd0);
    step(1'b0, '0, 1'b0, 1'b1, 1'b0, 4'd0, 16'd0, 16'd0);
    n_checks++; if (obs_valid !== 1'b1 || obs_data[15:0] !== 16'h0340 || obs_sat[0] !== 1'b0) begin
      n_err++; $display("FAIL mid_identity got=%b %h/%b want=1 0340/0", obs_valid, obs_data[15:0], obs_sat[0]); end
  endtask

`ifdef NFU3_BYPASS_EN
  task automatic test_bypass();
    do_reset();
    step(1'b0, '0, 1'b0, 1'b1, 1'b1, 4'd8, 16'h7FFF, 16'h0000);
    step(1'b1, rvec(16'h0FFF), 1'b1, 1'b1, 1'b0, 4'd0, 16'd0, 16'd0);
    step(1'b0, '0, 1'b0, 1'b1, 1'b0, 4'd0, 16'd0, 16'd0);
    step(1'b0, '0, 1'b0, 1'b1, 1'b0, 4'd0, 16'd0, 16'd0);
    n_checks++; if (obs_valid !== 1'b1 || obs_data[15:0] !== 16'h0FFF || obs_sat !== '0) begin
      n_err++; $display("FAIL bypass got=%b %h/%h want=1 0FFF/0", obs_valid, obs_data[15:0], obs_sat); end
  endtask
`endif

  task automatic test_random();
    logic [DW-1:0] pend;
    logic          pend_v, pbyp, rdy, we;
    logic [3:0]    wa;
    logic [15:0]   ca, cb;
    do_reset();
    pend = '0; pend_v = 1'b0; pbyp = 1'b0;
    for (int c = 0; c < 420; c++) begin
      if (!pend_v && $urandom_range(0, 3) != 0) begin
        pend = rvec(16'($urandom));
        pend_v = 1'b1;
`ifdef NFU3_BYPASS_EN
        pbyp = ($urandom_range(0, 3) == 0);
`endif
      end
      if (c >= 400) pend_v = 1'b0;
      rdy = ($urandom_range(0, 3) != 0) || (c >= 400);
      we  = ($urandom_range(0, 7) == 0);
      wa  = 4'($urandom);
      ca  = $urandom_range(0, 1) ? 16'($urandom) : 16'(int'($urandom_range(0, 767)) - 384);
      cb  = $urandom_range(0, 1) ? 16'($urandom) : 16'(int'($urandom_range(0, 1023)) - 512);
      step(pend_v, pend, pbyp, rdy, we, wa, ca, cb);
      n_checks++; if (obs_ready !== exp_ready || obs_valid !== exp_valid) begin
        n_err++; $display("FAIL rand_hs c=%0d got=%b%b want=%b%b", c, obs_ready, obs_valid, exp_ready, exp_valid); end
      if (exp_drain) begin
        n_checks++; if (obs_data !== exp_data || obs_sat !== exp_sat) begin
          n_err++; $display("FAIL rand_data c=%0d got=%h/%h want=%h/%h", c, obs_data, obs_sat, exp_data, exp_sat); end
      end
      if (pend_v && exp_ready) pend_v = 1'b0;
    end
  endtask

  initial begin
    rst = 1'b1;
    drive_idle();
    model_reset();
    test_reset();
    test_identity();
    test_coeff();
    test_sat();
    test_back_to_back();
    test_cfg_collision();
    test_reset_midflight();
`ifdef NFU3_BYPASS_EN
    test_bypass();
`endif
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
`default_nettype wire
